// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath width, default NOP encoding, fetch FSM
// state encoding and the sequential PC increment helper.
package cpu_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] NOP_INSTR_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } fetch_state_t;

    // Word-addressed sequential increment; 32'hFFFF_FFFF wraps to 0 naturally.
    function automatic logic [XLEN-1:0] pc_increment(input logic [XLEN-1:0] pc);
        return pc + XLEN'(1);
    endfunction

endpackage

// File: rtl/next_pc_sel.sv
// Next-PC selection for the fetch unit.
// Priority: WB redirect (older instruction) > EX redirect > sequential
// increment > hold current PC.
module next_pc_sel
    import cpu_pkg::*;
(
    input  logic [XLEN-1:0] i_pc,
    input  logic            i_advance,
    input  logic            i_ex_redirect,
    input  logic [XLEN-1:0] i_ex_target,
    input  logic            i_wb_redirect,
    input  logic [XLEN-1:0] i_wb_target,
    output logic [XLEN-1:0] o_next_pc,
    output logic            o_redirect
);

    // Priority mux selecting the PC to load on the next edge.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // no path through the if/else chain can infer a latch.
        o_next_pc = i_pc;
        if (i_wb_redirect) begin
            o_next_pc = i_wb_target;
        end else if (i_ex_redirect) begin
            o_next_pc = i_ex_target;
        end else if (i_advance) begin
            o_next_pc = pc_increment(i_pc);
        end
    end

    assign o_redirect = i_wb_redirect | i_ex_redirect;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: drives a synchronous instruction memory, presents
// fetched instructions to IF_ID, holds the payload across hazard stalls and
// services EX/WB redirects with a same-cycle flush.
// Optional build macro FETCH_PERF_CNT_EN adds saturating stall_cycles and
// redirect_count performance counters.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
    parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            stall,
    input  logic            ex_redirect,
    input  logic [XLEN-1:0] ex_target,
    input  logic            wb_redirect,
    input  logic [XLEN-1:0] wb_target,
    output logic [XLEN-1:0] imem_addr,
    input  logic [XLEN-1:0] imem_data,
    output logic            if_valid,
    output logic [XLEN-1:0] if_pc,
    output logic [XLEN-1:0] if_instr,
    output logic            flush
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]     stall_cycles,
    output logic [31:0]     redirect_count
`endif
);

    fetch_state_t    r_state;
    fetch_state_t    w_next_state;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] w_next_pc;
    logic [XLEN-1:0] r_fetch_pc;     // address whose data is on imem_data now
    logic            r_fetch_valid;  // imem_data carries a real instruction
    logic [XLEN-1:0] r_hold_pc;
    logic [XLEN-1:0] r_hold_instr;
    logic            w_redirect;
    logic            w_advance;
    logic            w_capture;

    // The fetch pipeline moves whenever it is running and not stalled; a
    // HOLD exit behaves exactly like a normal advance because the frozen PC
    // has been re-read from memory throughout the stall.
    assign w_advance = (r_state != ST_IDLE) && !stall;

    // Freeze a valid payload into the hold registers on the stall's first cycle.
    assign w_capture = (r_state == ST_RUN) && stall && r_fetch_valid && !w_redirect;

    assign imem_addr = r_pc;
    assign flush     = w_redirect & ~reset;

    next_pc_sel u_next_pc_sel (
        .i_pc          (r_pc),
        .i_advance     (w_advance),
        .i_ex_redirect (ex_redirect),
        .i_ex_target   (ex_target),
        .i_wb_redirect (wb_redirect),
        .i_wb_target   (wb_target),
        .o_next_pc     (w_next_pc),
        .o_redirect    (w_redirect)
    );

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of block ordering.
            r_state <= w_next_state;
        end
    end

    // Next-state logic; a redirect overrides stall and always lands in RUN.
    always_comb begin
        w_next_state = r_state;
        if (w_redirect) begin
            w_next_state = ST_RUN;
        end else begin
            case (r_state)
                ST_IDLE: w_next_state = ST_RUN;
                ST_RUN:  if (stall && r_fetch_valid) w_next_state = ST_HOLD;
                ST_HOLD: if (!stall) w_next_state = ST_RUN;
                default: w_next_state = ST_IDLE;
            endcase
        end
    end

    // Output logic: live memory data in RUN, frozen payload in HOLD.
    always_comb begin
        if_valid = 1'b0;
        if_pc    = r_fetch_pc;
        if_instr = NOP_INSTR;
        case (r_state)
            ST_RUN: begin
                if_valid = r_fetch_valid;
                if_instr = r_fetch_valid ? imem_data : NOP_INSTR;
            end
            ST_HOLD: begin
                if_valid = 1'b1;
                if_pc    = r_hold_pc;
                if_instr = r_hold_instr;
            end
            default: begin
                if_valid = 1'b0;
            end
        endcase
    end

    // PC and in-flight fetch tracking; a redirect squashes the fetch in flight.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_pc          <= RESET_PC;
            r_fetch_pc    <= '0;
            r_fetch_valid <= 1'b0;
        end else begin
            r_pc <= w_next_pc;
            if (w_redirect) begin
                r_fetch_valid <= 1'b0;
            end else if (w_advance) begin
                r_fetch_valid <= 1'b1;
                r_fetch_pc    <= r_pc;
            end
        end
    end

    // Hold registers capture the stalled instruction and its address.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_hold_pc    <= '0;
            r_hold_instr <= '0;
        end else if (w_capture) begin
            r_hold_pc    <= r_fetch_pc;
            r_hold_instr <= imem_data;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] r_stall_cycles;
    logic [31:0] r_redirect_count;

    // Saturating counters of HOLD cycles and accepted redirects.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_stall_cycles   <= '0;
            r_redirect_count <= '0;
        end else begin
            if ((r_state == ST_HOLD) && (r_stall_cycles != 32'hFFFF_FFFF)) begin
                r_stall_cycles <= r_stall_cycles + 32'd1;
            end
            if (w_redirect && (r_redirect_count != 32'hFFFF_FFFF)) begin
                r_redirect_count <= r_redirect_count + 32'd1;
            end
        end
    end

    assign stall_cycles   = r_stall_cycles;
    assign redirect_count = r_redirect_count;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed vector table from reset,
// hand-written corner sequences, then randomized traffic against a
// stream-level reference model (expected next accepted PC).
module tb_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        ex_redirect = 1'b0;
    logic [31:0] ex_target = '0;
    logic        wb_redirect = 1'b0;
    logic [31:0] wb_target = '0;
    logic [31:0] imem_addr;
    logic [31:0] imem_data = '0;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        flush;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] stall_cycles;
    logic [31:0] redirect_count;
`endif

    int n_checks = 0;
    int n_errors = 0;

    fetch_unit #(
        .RESET_PC  (RST_PC),
        .NOP_INSTR (NOP)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .stall       (stall),
        .ex_redirect (ex_redirect),
        .ex_target   (ex_target),
        .wb_redirect (wb_redirect),
        .wb_target   (wb_target),
        .imem_addr   (imem_addr),
        .imem_data   (imem_data),
        .if_valid    (if_valid),
        .if_pc       (if_pc),
        .if_instr    (if_instr),
        .flush       (flush)
`ifdef FETCH_PERF_CNT_EN
        ,
        .stall_cycles   (stall_cycles),
        .redirect_count (redirect_count)
`endif
    );

    always #5 clock = ~clock;

    // Instruction memory contents are a fixed hash of the address.
    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        return (addr * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
    endfunction

    // Synchronous memory: data one cycle after the address.
    always @(posedge clock) imem_data <= mem_word(imem_addr);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs and move to the sampling point (negedge).
    task automatic apply(input logic s, input logic exr, input logic [31:0] ext,
                         input logic wbr, input logic [31:0] wbt);
        stall       = s;
        ex_redirect = exr;
        ex_target   = ext;
        wb_redirect = wbr;
        wb_target   = wbt;
        @(negedge clock);
    endtask

    task automatic next_edge();
        @(posedge clock);
        #1;
    endtask

    // Check the visible fetch output against an expected valid/pc pair.
    task automatic check_out(input string tag, input logic ev, input logic [31:0] epc);
        check({tag, "_valid"}, {31'd0, if_valid}, {31'd0, ev});
        if (ev) begin
            check({tag, "_pc"}, if_pc, epc);
            check({tag, "_instr"}, if_instr, mem_word(epc));
        end else begin
            check({tag, "_nop"}, if_instr, NOP);
        end
    endtask

    typedef struct {
        logic        stall;
        logic        ex_r;
        logic [31:0] ex_t;
        logic        wb_r;
        logic [31:0] wb_t;
        logic        exp_valid;
        logic [31:0] exp_pc;
        logic        exp_flush;
    } vec_t;

    vec_t vecs[23];

    function automatic vec_t mk(input logic s, input logic exr, input logic [31:0] ext,
                                input logic wbr, input logic [31:0] wbt,
                                input logic ev, input logic [31:0] epc, input logic ef);
        vec_t v;
        v.stall = s; v.ex_r = exr; v.ex_t = ext; v.wb_r = wbr; v.wb_t = wbt;
        v.exp_valid = ev; v.exp_pc = epc; v.exp_flush = ef;
        return v;
    endfunction

    logic [31:0] exp_next;
    logic        pend_inv;
    int          inv_cnt;
    logic        r_s, r_ex, r_wb;
    logic [31:0] r_ext, r_wbt;

    initial begin
        // One row per cycle starting at the cycle in which reset is released.
        vecs[0]  = mk(0, 0, 0,      0, 0,      0, 0,      0);
        vecs[1]  = mk(0, 0, 0,      0, 0,      0, 0,      0);
        vecs[2]  = mk(0, 0, 0,      0, 0,      1, 0,      0);
        vecs[3]  = mk(0, 0, 0,      0, 0,      1, 1,      0);
        vecs[4]  = mk(0, 0, 0,      0, 0,      1, 2,      0);
        vecs[5]  = mk(0, 0, 0,      0, 0,      1, 3,      0);
        vecs[6]  = mk(0, 0, 0,      0, 0,      1, 4,      0);
        vecs[7]  = mk(1, 0, 0,      0, 0,      1, 5,      0);
        vecs[8]  = mk(1, 0, 0,      0, 0,      1, 5,      0);
        vecs[9]  = mk(1, 0, 0,      0, 0,      1, 5,      0);
        vecs[10] = mk(0, 0, 0,      0, 0,      1, 5,      0);
        vecs[11] = mk(0, 0, 0,      0, 0,      1, 6,      0);
        vecs[12] = mk(0, 1, 32'h40, 0, 0,      1, 7,      1);
        vecs[13] = mk(0, 0, 0,      0, 0,      0, 0,      0);
        vecs[14] = mk(0, 0, 0,      0, 0,      1, 32'h40, 0);
        vecs[15] = mk(0, 1, 32'h40, 1, 32'h80, 1, 32'h41, 1);
        vecs[16] = mk(0, 0, 0,      0, 0,      0, 0,      0);
        vecs[17] = mk(0, 0, 0,      0, 0,      1, 32'h80, 0);
        vecs[18] = mk(1, 0, 0,      0, 0,      1, 32'h81, 0);
        vecs[19] = mk(1, 1, 32'h20, 0, 0,      1, 32'h81, 1);
        vecs[20] = mk(0, 0, 0,      0, 0,      0, 0,      0);
        vecs[21] = mk(0, 0, 0,      0, 0,      1, 32'h20, 0);
        vecs[22] = mk(0, 0, 0,      0, 0,      1, 32'h21, 0);

        // Reset state.
        #2;
        check("rst_valid", {31'd0, if_valid}, 32'd0);
        check("rst_pc", if_pc, 32'd0);
        check("rst_instr", if_instr, NOP);
        check("rst_addr", imem_addr, RST_PC);
        check("rst_flush", {31'd0, flush}, 32'd0);
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;

        // Directed table.
        for (int i = 0; i < 23; i++) begin
            apply(vecs[i].stall, vecs[i].ex_r, vecs[i].ex_t, vecs[i].wb_r, vecs[i].wb_t);
            check_out($sformatf("vec%0d", i), vecs[i].exp_valid, vecs[i].exp_pc);
            check($sformatf("vec%0d_flush", i), {31'd0, flush}, {31'd0, vecs[i].exp_flush});
            next_edge();
        end
`ifdef FETCH_PERF_CNT_EN
        check("cnt_stall_cycles", stall_cycles, 32'd4);
        check("cnt_redirects", redirect_count, 32'd3);
`endif

        // Stall while nothing valid is presented: PC frozen, no hold capture.
        apply(0, 1, 32'h100, 0, 0);
        check("sinv_flush", {31'd0, flush}, 32'd1);
        next_edge();
        apply(1, 0, 0, 0, 0); check_out("sinv_a", 0, 0); next_edge();
        apply(1, 0, 0, 0, 0); check_out("sinv_b", 0, 0); next_edge();
        apply(0, 0, 0, 0, 0); check_out("sinv_c", 0, 0); next_edge();
        apply(0, 0, 0, 0, 0); check_out("sinv_d", 1, 32'h100); next_edge();
        apply(0, 0, 0, 0, 0); check_out("sinv_e", 1, 32'h101); next_edge();

        // PC wrap from all-ones to zero.
        apply(0, 0, 0, 1, 32'hFFFF_FFFF); next_edge();
        apply(0, 0, 0, 0, 0); check_out("wrap_a", 0, 0); next_edge();
        apply(0, 0, 0, 0, 0); check_out("wrap_b", 1, 32'hFFFF_FFFF); next_edge();
        apply(0, 0, 0, 0, 0); check_out("wrap_c", 1, 32'h0); next_edge();

        // Reset asserted mid-HOLD with a redirect pending.
        apply(1, 0, 0, 0, 0); check_out("rh_a", 1, 32'h1); next_edge();
        apply(1, 0, 0, 0, 0); check_out("rh_hold", 1, 32'h1);
        ex_redirect = 1'b1;
        ex_target   = 32'h300;
        #1 reset = 1'b1;
        #1;
        check("rh_valid", {31'd0, if_valid}, 32'd0);
        check("rh_pc", if_pc, 32'd0);
        check("rh_instr", if_instr, NOP);
        check("rh_flush", {31'd0, flush}, 32'd0);
        check("rh_addr", imem_addr, RST_PC);
`ifdef FETCH_PERF_CNT_EN
        check("rh_cnt_stall", stall_cycles, 32'd0);
        check("rh_cnt_redir", redirect_count, 32'd0);
`endif
        next_edge();
        apply(0, 0, 0, 0, 0);
        next_edge();
        reset = 1'b0;
        apply(0, 0, 0, 0, 0); check_out("rr_a", 0, 0); next_edge();
        apply(0, 0, 0, 0, 0); check_out("rr_b", 0, 0); next_edge();
        apply(0, 0, 0, 0, 0); check_out("rr_c", 1, RST_PC); next_edge();
`ifdef FETCH_PERF_CNT_EN
        check("rr_cnt_stall", stall_cycles, 32'd0);
        check("rr_cnt_redir", redirect_count, 32'd0);
`endif

        // Randomized traffic against the stream model.
        reset = 1'b1;
        next_edge();
        reset    = 1'b0;
        exp_next = RST_PC;
        pend_inv = 1'b0;
        inv_cnt  = 0;
        for (int c = 0; c < 600; c++) begin
            r_s   = ($urandom_range(0, 9) < 3);
            r_ex  = ($urandom_range(0, 19) == 0);
            r_wb  = ($urandom_range(0, 24) == 0);
            r_ext = $urandom();
            r_wbt = $urandom();
            apply(r_s, r_ex, r_ext, r_wb, r_wbt);
            check("rnd_flush", {31'd0, flush}, {31'd0, (r_ex | r_wb)});
            if (pend_inv) check("rnd_squash", {31'd0, if_valid}, 32'd0);
            if (if_valid) begin
                check("rnd_pc", if_pc, exp_next);
                check("rnd_instr", if_instr, mem_word(exp_next));
                inv_cnt = 0;
            end else begin
                check("rnd_nop", if_instr, NOP);
                if (!r_s) inv_cnt++;
            end
            check("rnd_progress", {31'd0, (inv_cnt <= 2)}, 32'd1);
            if (r_ex | r_wb) begin
                exp_next = r_wb ? r_wbt : r_ext;
                pend_inv = 1'b1;
                inv_cnt  = 0;
            end else begin
                pend_inv = 1'b0;
                if (if_valid && !r_s) exp_next = exp_next + 32'd1;
            end
            next_edge();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, first instruction address fetched after reset.
REQ-002 Parameter NOP_INSTR, default 32'h0000_0000, instruction presented while if_valid=0.
REQ-003 Port clock, input, 1, sole clock; all state updates on rising edge.
REQ-004 Port reset, input, 1, asynchronous, active-high.
REQ-005 Port stall, input, 1, hazard unit request to hold the IF/ID payload.
REQ-006 Port ex_redirect, input, 1, EX-stage branch/jump taken.
REQ-007 Port ex_target, input, 32, EX-stage redirect address.
REQ-008 Port wb_redirect, input, 1, jumpMem_WB taken.
REQ-009 Port wb_target, input, 32, memory-sourced jump address (data_WB).
REQ-010 Port imem_addr, output, 32, word address to synchronous instruction memory.
REQ-011 Port imem_data, input, 32, instruction returned one cycle after imem_addr.
REQ-012 Port if_valid, output, 1, if_pc/if_instr hold a real instruction.
REQ-013 Port if_pc, output, 32, address of if_instr.
REQ-014 Port if_instr, output, 32, fetched instruction to IF_ID.
REQ-015 Port flush, output, 1, squash IF_ID and ID_EXMEM contents this cycle.

Function
REQ-016 The block SHALL hold a PC register; imem_addr SHALL equal the PC register combinationally.
REQ-017 Sequential increment SHALL be PC+1 (word addressing), wrapping 32'hFFFF_FFFF to 0.
REQ-018 States SHALL be IDLE, RUN, HOLD; IDLE entered on reset, IDLE->RUN unconditionally next edge.
REQ-019 In RUN with no stall/redirect: PC advances, if_pc = previous PC, if_instr = imem_data, if_valid=1.
REQ-020 RUN->HOLD on stall with if_valid=1: capture imem_data and its pc into hold registers, freeze PC.
REQ-021 In HOLD, if_instr/if_pc SHALL come from hold registers, if_valid=1, PC frozen; HOLD->RUN when stall deasserts, resuming at PC without loss or duplication.
REQ-022 Any redirect SHALL assert flush combinationally in the same cycle, override stall, load PC with target, enter RUN.
REQ-023 Both redirects in one cycle: wb_redirect SHALL win (older instruction); ex_target ignored.
REQ-024 Redirect in cycle N: if_valid=0 in cycle N+1; if_valid=1 with if_pc=target in cycle N+2 absent further events.
REQ-025 Whenever if_valid=0, if_instr SHALL equal NOP_INSTR.
REQ-026 Stall while if_valid=0 SHALL freeze PC; no hold capture.

Reset
REQ-027 Reset SHALL immediately force PC=RESET_PC, state IDLE, if_valid=0, if_pc=0, if_instr=NOP_INSTR, flush=0, hold registers 0.
REQ-028 Reset mid-HOLD or mid-redirect SHALL discard held/pending data; first valid output RESET_PC two edges after reset release.

Configuration
REQ-029 With FETCH_PERF_CNT_EN defined, outputs stall_cycles[31:0] and redirect_count[31:0] SHALL exist, counting HOLD cycles and accepted redirects, saturating at all-ones, cleared by reset.
REQ-030 Without FETCH_PERF_CNT_EN, those ports and counters SHALL be absent; all other behaviour identical.

Structure
REQ-031 State encoding (IDLE/RUN/HOLD), XLEN=32 and NOP_INSTR default SHALL live in shared package cpu_pkg.
REQ-032 Next-PC selection SHALL be sub-module next_pc_sel (combinational priority WB > EX > increment > hold).

Verification
REQ-033 Reset release, no stall -> if_valid rises second edge; if_pc sequence 0,1,2,3 on consecutive cycles.
REQ-034 Stall 3 cycles at if_pc=5 -> if_pc=5, if_instr constant for 3 cycles; then 6,7 with no gap.
REQ-035 ex_redirect to 32'h40 at cycle N -> flush=1 at N, if_valid=0 at N+1, if_pc=32'h40 at N+2.
REQ-036 ex_redirect 32'h40 and wb_redirect 32'h80 same cycle -> if_pc=32'h80 two cycles later.
REQ-037 Redirect to 32'h20 while stall=1 -> redirect taken, flush=1, HOLD exited, if_pc=32'h20 at N+2.
REQ-038 Reset asserted mid-HOLD -> outputs reset same cycle; if_pc=RESET_PC after release; counters 0 when FETCH_PERF_CNT_EN defined.
